// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares a single memory request/response port between an instruction-fetch
// requester (IF, read-only) and a load/store requester (LS). Only one
// transaction is in flight at a time. The controller walks through three
// states: IDLE (grant), REQ (present the request to memory) and RESP (wait for
// the memory response and forward it to the owner).
//
// Arbitration:
//   default            : fixed priority, LS beats IF
//   ARB_ROUND_ROBIN_EN : on a simultaneous request, the grant goes to the
//                        requester that was not granted last
//
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   if_req_valid_i/_ready_o      fetch request handshake
//   if_req_addr_i                fetch address
//   if_resp_valid_o/_data_o      fetch response (single-cycle pulse)
//   ls_req_valid_i/_ready_o      load/store request handshake
//   ls_req_addr_i/_we_i/_wdata_i/_wmask_i  load/store request fields
//   ls_resp_valid_o/_data_o      load/store response / store acknowledge
//   mem_req_valid_o/_ready_i     memory request handshake
//   mem_req_addr_o/_we_o/_wdata_o/_wmask_o memory request fields
//   mem_resp_valid_i/_data_i     memory response
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                if_req_valid_i,
    output logic                if_req_ready_o,
    input  logic [ADDR_W-1:0]   if_req_addr_i,
    output logic                if_resp_valid_o,
    output logic [DATA_W-1:0]   if_resp_data_o,

    input  logic                ls_req_valid_i,
    output logic                ls_req_ready_o,
    input  logic [ADDR_W-1:0]   ls_req_addr_i,
    input  logic                ls_req_we_i,
    input  logic [DATA_W-1:0]   ls_req_wdata_i,
    input  logic [DATA_W/8-1:0] ls_req_wmask_i,
    output logic                ls_resp_valid_o,
    output logic [DATA_W-1:0]   ls_resp_data_o,

    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic [ADDR_W-1:0]   mem_req_addr_o,
    output logic                mem_req_we_o,
    output logic [DATA_W-1:0]   mem_req_wdata_o,
    output logic [DATA_W/8-1:0] mem_req_wmask_o,
    input  logic                mem_resp_valid_i,
    input  logic [DATA_W-1:0]   mem_resp_data_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic                we_q,    we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wmask_q, wmask_d;

    logic grant_if, grant_ls;

`ifdef ARB_ROUND_ROBIN_EN
    // Remembers who won the last grant; OWN_IF after reset, so LS wins the
    // first simultaneous request.
    owner_e last_q, last_d;

    always_comb begin
        grant_ls = ls_req_valid_i && (!if_req_valid_i || (last_q == OWN_IF));
        grant_if = if_req_valid_i && !grant_ls;
    end
`else
    always_comb begin
        grant_ls = ls_req_valid_i;
        grant_if = if_req_valid_i && !ls_req_valid_i;
    end
`endif

    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        addr_d          = addr_q;
        we_d            = we_q;
        wdata_d         = wdata_q;
        wmask_d         = wmask_q;
        if_req_ready_o  = 1'b0;
        ls_req_ready_o  = 1'b0;
        mem_req_valid_o = 1'b0;
        if_resp_valid_o = 1'b0;
        ls_resp_valid_o = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_d          = last_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (grant_ls) begin
                    ls_req_ready_o = 1'b1;
                    owner_d        = OWN_LS;
                    addr_d         = ls_req_addr_i;
                    we_d           = ls_req_we_i;
                    wdata_d        = ls_req_wdata_i;
                    wmask_d        = ls_req_wmask_i;
                    state_d        = S_REQ;
                end else if (grant_if) begin
                    // Fetches are reads: never let stale store fields leak out.
                    if_req_ready_o = 1'b1;
                    owner_d        = OWN_IF;
                    addr_d         = if_req_addr_i;
                    we_d           = 1'b0;
                    wdata_d        = '0;
                    wmask_d        = '0;
                    state_d        = S_REQ;
                end
`ifdef ARB_ROUND_ROBIN_EN
                if (grant_ls || grant_if) begin
                    last_d = grant_ls ? OWN_LS : OWN_IF;
                end
`endif
            end
            S_REQ: begin
                mem_req_valid_o = 1'b1;
                if (mem_req_ready_i) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (mem_resp_valid_i) begin
                    if_resp_valid_o = (owner_q == OWN_IF);
                    ls_resp_valid_o = (owner_q == OWN_LS);
                    state_d         = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Memory request fields come only from the holding registers, so the
    // requesters are free to change their inputs after the grant cycle.
    assign mem_req_addr_o  = addr_q;
    assign mem_req_we_o    = we_q;
    assign mem_req_wdata_o = wdata_q;
    assign mem_req_wmask_o = wmask_q;
    assign if_resp_data_o  = mem_resp_data_i;
    assign ls_resp_data_o  = mem_resp_data_i;

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values. The holding registers are reset too (they are small and
    // drive the memory port directly), unlike a RAM array which would not be.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            owner_q <= OWN_IF;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q  <= OWN_IF;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q  <= last_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter. A cycle-by-cycle vector table drives
// inputs on the falling edge and checks the outputs 1 ns later, before the
// next rising edge. A hand-written loop then streams back-to-back fetches
// against a zero-wait memory. Define ARB_ROUND_ROBIN_EN for both the bench and
// the design to check the round-robin build.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int MW = DW / 8;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req_valid, if_req_ready, if_resp_valid;
    logic [AW-1:0] if_req_addr;
    logic [DW-1:0] if_resp_data;
    logic          ls_req_valid, ls_req_ready, ls_req_we, ls_resp_valid;
    logic [AW-1:0] ls_req_addr;
    logic [DW-1:0] ls_req_wdata, ls_resp_data;
    logic [MW-1:0] ls_req_wmask;
    logic          mem_req_valid, mem_req_ready, mem_req_we, mem_resp_valid;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_wdata, mem_resp_data;
    logic [MW-1:0] mem_req_wmask;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_req_valid_i   (if_req_valid),
        .if_req_ready_o   (if_req_ready),
        .if_req_addr_i    (if_req_addr),
        .if_resp_valid_o  (if_resp_valid),
        .if_resp_data_o   (if_resp_data),
        .ls_req_valid_i   (ls_req_valid),
        .ls_req_ready_o   (ls_req_ready),
        .ls_req_addr_i    (ls_req_addr),
        .ls_req_we_i      (ls_req_we),
        .ls_req_wdata_i   (ls_req_wdata),
        .ls_req_wmask_i   (ls_req_wmask),
        .ls_resp_valid_o  (ls_resp_valid),
        .ls_resp_data_o   (ls_resp_data),
        .mem_req_valid_o  (mem_req_valid),
        .mem_req_ready_i  (mem_req_ready),
        .mem_req_addr_o   (mem_req_addr),
        .mem_req_we_o     (mem_req_we),
        .mem_req_wdata_o  (mem_req_wdata),
        .mem_req_wmask_o  (mem_req_wmask),
        .mem_resp_valid_i (mem_resp_valid),
        .mem_resp_data_i  (mem_resp_data)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic          rst;
        logic          ifv;
        logic [AW-1:0] ifa;
        logic          lsv;
        logic [AW-1:0] lsa;
        logic          lwe;
        logic [DW-1:0] lwd;
        logic [MW-1:0] lwm;
        logic          mrdy;
        logic          mrv;
        logic [DW-1:0] mrd;
        logic          e_ifr;
        logic          e_lsr;
        logic          e_mv;
        logic [AW-1:0] e_ma;
        logic          e_mwe;
        logic [DW-1:0] e_mwd;
        logic [MW-1:0] e_mwm;
        logic          e_ifrv;
        logic          e_lsrv;
    } vec_t;

    function automatic vec_t mk(
        logic rst, logic ifv, logic [AW-1:0] ifa,
        logic lsv, logic [AW-1:0] lsa, logic lwe, logic [DW-1:0] lwd, logic [MW-1:0] lwm,
        logic mrdy, logic mrv, logic [DW-1:0] mrd,
        logic e_ifr, logic e_lsr, logic e_mv, logic [AW-1:0] e_ma, logic e_mwe,
        logic [DW-1:0] e_mwd, logic [MW-1:0] e_mwm, logic e_ifrv, logic e_lsrv);
        vec_t v;
        v.rst = rst;   v.ifv = ifv;   v.ifa = ifa;
        v.lsv = lsv;   v.lsa = lsa;   v.lwe = lwe;   v.lwd = lwd;   v.lwm = lwm;
        v.mrdy = mrdy; v.mrv = mrv;   v.mrd = mrd;
        v.e_ifr = e_ifr; v.e_lsr = e_lsr; v.e_mv = e_mv; v.e_ma = e_ma;
        v.e_mwe = e_mwe; v.e_mwd = e_mwd; v.e_mwm = e_mwm;
        v.e_ifrv = e_ifrv; v.e_lsrv = e_lsrv;
        return v;
    endfunction

    localparam logic [AW-1:0] A_F  = 64'h8000_0000;
    localparam logic [AW-1:0] A_S  = 64'h8000_1000;
    localparam logic [AW-1:0] A_I1 = 64'h8000_0100;
    localparam logic [AW-1:0] A_L1 = 64'h8000_2000;
    localparam logic [AW-1:0] A_L2 = 64'h8000_2008;
    localparam logic [AW-1:0] A_I3 = 64'h8000_0200;
    localparam logic [AW-1:0] A_I4 = 64'h8000_0300;

    vec_t tbl[$];

    initial begin
        // Idle defaults, then reset for two edges before the table starts.
        rst_n = 1'b0;
        if_req_valid = 0; if_req_addr = '0;
        ls_req_valid = 0; ls_req_addr = '0; ls_req_we = 0; ls_req_wdata = '0; ls_req_wmask = '0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
        repeat (2) @(posedge clk);

        //                rst ifv ifa     lsv lsa       we wd              wm     rdy rv rd
        //                    e_ifr e_lsr e_mv e_ma e_mwe e_mwd e_mwm e_ifrv e_lsrv
        // reset state
        tbl.push_back(mk(0, 0, 0,      0, 0,      0, 0,             0,     0, 0, 0,
                         0, 0, 0, 0,    0, 0,             0,     0, 0));
        // single fetch, two memory wait cycles
        tbl.push_back(mk(1, 1, A_F,    0, 0,      0, 0,             0,     0, 0, 0,
                         1, 0, 0, 0,    0, 0,             0,     0, 0));
        tbl.push_back(mk(1, 0, 0,      0, 0,      0, 0,             0,     0, 0, 0,
                         0, 0, 1, A_F,  0, 0,             0,     0, 0));
        tbl.push_back(mk(1, 0, 0,      0, 0,      0, 0,             0,     0, 0, 0,
                         0, 0, 1, A_F,  0, 0,             0,     0, 0));
        tbl.push_back(mk(1, 0, 0,      0, 0,      0, 0,             0,     1, 0, 0,
                         0, 0, 1, A_F,  0, 0,             0,     0, 0));
        tbl.push_back(mk(1, 0, 0,      0, 0,      0, 0,             0,     0, 0, 0,
                         0, 0, 0, 0,    0, 0,             0,     0, 0));
        tbl.push_back(mk(1, 0, 0,      0, 0,      0, 0,             0,     0, 1, 64'h0010_0073,
                         0, 0, 0, 0,    0, 0,             0,     1, 0));
        // stray memory response in IDLE is ignored
        tbl.push_back(mk(1, 0, 0,      0, 0,      0, 0,             0,     0, 1, 64'hBAD,
                         0, 0, 0, 0,    0, 0,             0,     0, 0));
        // store; then five stalled cycles with both requesters asking
        tbl.push_back(mk(1, 0, 0,      1, A_S,    1, 64'hDEAD_BEEF, 8'hFF, 0, 0, 0,
                         0, 1, 0, 0,    0, 0,             0,     0, 0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(1, 1, 64'h1111, 1, 64'h2222, 0, 0,       0,     0, 0, 0,
                             0, 0, 1, A_S,  1, 64'hDEAD_BEEF, 8'hFF, 0, 0));
        tbl.push_back(mk(1, 1, 64'h1111, 1, 64'h2222, 0, 0,           0,     1, 0, 0,
                         0, 0, 1, A_S,  1, 64'hDEAD_BEEF, 8'hFF, 0, 0));
        tbl.push_back(mk(1, 1, 64'h1111, 0, 0,    0, 0,             0,     0, 1, 64'h1234,
                         0, 0, 0, 0,    0, 0,             0,     0, 1));
        // fresh reset, then two simultaneous requests
        tbl.push_back(mk(0, 0, 0,      0, 0,      0, 0,             0,     0, 0, 0,
                         0, 0, 0, 0,    0, 0,             0,     0, 0));
        tbl.push_back(mk(1, 1, A_I1,   1, A_L1,   0, 0,             0,     0, 0, 0,
                         0, 1, 0, 0,    0, 0,             0,     0, 0));
        tbl.push_back(mk(1, 0, 0,      0, 0,      0, 0,             0,     1, 0, 0,
                         0, 0, 1, A_L1, 0, 0,             0,     0, 0));
        tbl.push_back(mk(1, 0, 0,      0, 0,      0, 0,             0,     0, 1, 64'h55,
                         0, 0, 0, 0,    0, 0,             0,     0, 1));
        tbl.push_back(mk(1, 1, A_I1,   1, A_L2,   0, 0,             0,     0, 0, 0,
                         RR, !RR, 0, 0, 0, 0,             0,     0, 0));
        tbl.push_back(mk(1, 0, 0,      0, 0,      0, 0,             0,     1, 0, 0,
                         0, 0, 1, RR ? A_I1 : A_L2, 0, 0,  0,     0, 0));
        tbl.push_back(mk(1, 0, 0,      0, 0,      0, 0,             0,     0, 1, 64'h66,
                         0, 0, 0, 0,    0, 0,             0,     RR, !RR));
        // reset while in RESP, then a stray response
        tbl.push_back(mk(1, 1, A_I3,   0, 0,      0, 0,             0,     0, 0, 0,
                         1, 0, 0, 0,    0, 0,             0,     0, 0));
        tbl.push_back(mk(1, 0, 0,      0, 0,      0, 0,             0,     1, 0, 0,
                         0, 0, 1, A_I3, 0, 0,             0,     0, 0));
        tbl.push_back(mk(0, 0, 0,      0, 0,      0, 0,             0,     0, 0, 0,
                         0, 0, 0, 0,    0, 0,             0,     0, 0));
        tbl.push_back(mk(1, 1, A_I4,   0, 0,      0, 0,             0,     0, 1, 64'h77,
                         1, 0, 0, 0,    0, 0,             0,     0, 0));
        tbl.push_back(mk(1, 0, 0,      0, 0,      0, 0,             0,     1, 0, 0,
                         0, 0, 1, A_I4, 0, 0,             0,     0, 0));
        tbl.push_back(mk(1, 0, 0,      0, 0,      0, 0,             0,     0, 1, 64'h88,
                         0, 0, 0, 0,    0, 0,             0,     1, 0));

        foreach (tbl[i]) begin
            @(negedge clk);
            rst_n          = tbl[i].rst;
            if_req_valid   = tbl[i].ifv;
            if_req_addr    = tbl[i].ifa;
            ls_req_valid   = tbl[i].lsv;
            ls_req_addr    = tbl[i].lsa;
            ls_req_we      = tbl[i].lwe;
            ls_req_wdata   = tbl[i].lwd;
            ls_req_wmask   = tbl[i].lwm;
            mem_req_ready  = tbl[i].mrdy;
            mem_resp_valid = tbl[i].mrv;
            mem_resp_data  = tbl[i].mrd;
            #1;
            check($sformatf("v%0d if_req_ready", i),  if_req_ready,  tbl[i].e_ifr);
            check($sformatf("v%0d ls_req_ready", i),  ls_req_ready,  tbl[i].e_lsr);
            check($sformatf("v%0d mem_req_valid", i), mem_req_valid, tbl[i].e_mv);
            check($sformatf("v%0d if_resp_valid", i), if_resp_valid, tbl[i].e_ifrv);
            check($sformatf("v%0d ls_resp_valid", i), ls_resp_valid, tbl[i].e_lsrv);
            if (tbl[i].e_mv) begin
                check($sformatf("v%0d mem_req_addr", i),  mem_req_addr,  tbl[i].e_ma);
                check($sformatf("v%0d mem_req_we", i),    mem_req_we,    tbl[i].e_mwe);
                check($sformatf("v%0d mem_req_wdata", i), mem_req_wdata, tbl[i].e_mwd);
                check($sformatf("v%0d mem_req_wmask", i), mem_req_wmask, tbl[i].e_mwm);
            end
            if (tbl[i].e_ifrv) check($sformatf("v%0d if_resp_data", i), if_resp_data, tbl[i].mrd);
            if (tbl[i].e_lsrv) check($sformatf("v%0d ls_resp_data", i), ls_resp_data, tbl[i].mrd);
        end

        // Back-to-back fetches against a zero-wait memory that answers the
        // cycle after each handshake with data = address ^ 0xA5.
        begin
            logic [AW-1:0] addrs [4];
            logic          pend;
            logic [AW-1:0] pend_addr;
            int            granted, sent, got, last_grant;
            addrs[0] = 64'h8000_0400; addrs[1] = 64'h8000_0404;
            addrs[2] = 64'h8000_0408; addrs[3] = 64'h8000_040C;
            pend = 0; pend_addr = '0;
            granted = 0; sent = 0; got = 0; last_grant = -1;
            for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
                @(negedge clk);
                rst_n          = 1'b1;
                ls_req_valid   = 1'b0;
                if_req_valid   = (granted < 4);
                if_req_addr    = addrs[granted < 4 ? granted : 3];
                mem_req_ready  = 1'b1;
                mem_resp_valid = pend;
                mem_resp_data  = pend_addr ^ 64'hA5;
                #1;
                if (if_req_ready) begin
                    if (last_grant >= 0) check("b2b grant spacing", cyc - last_grant, 3);
                    last_grant = cyc;
                    granted++;
                end
                if (mem_req_valid) begin
                    check("b2b mem_req_addr order", mem_req_addr, addrs[sent]);
                    sent++;
                end
                if (if_resp_valid) begin
                    check("b2b if_resp_data", if_resp_data, addrs[got] ^ 64'hA5);
                    got++;
                end
                check("b2b ls_resp_valid", ls_resp_valid, 0);
                pend      = mem_req_valid && mem_req_ready;
                pend_addr = mem_req_addr;
            end
            check("b2b responses received", got, 4);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 64, request address width in bits.
REQ-002 Parameter: DATA_W, default 64, data width in bits; write mask width is DATA_W/8.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 if_req_valid / if_req_ready  input / output  1 / 1  fetch request handshake; fetch port is read-only.
REQ-006 if_req_addr  input  ADDR_W  fetch address.
REQ-007 if_resp_valid / if_resp_data  output / output  1 / DATA_W  fetch response; single-cycle pulse, no backpressure.
REQ-008 ls_req_valid / ls_req_ready  input / output  1 / 1  load/store request handshake.
REQ-009 ls_req_addr / ls_req_we / ls_req_wdata / ls_req_wmask  input  ADDR_W / 1 / DATA_W / DATA_W/8  load/store request fields.
REQ-010 ls_resp_valid / ls_resp_data  output / output  1 / DATA_W  load/store response; also pulses as the store acknowledge.
REQ-011 mem_req_valid / mem_req_ready  output / input  1 / 1  shared memory port request handshake.
REQ-012 mem_req_addr / mem_req_we / mem_req_wdata / mem_req_wmask  output  ADDR_W / 1 / DATA_W / DATA_W/8  shared memory port request fields.
REQ-013 mem_resp_valid / mem_resp_data  input / input  1 / DATA_W  memory response.

Function
REQ-014 States: IDLE, REQ, RESP; exactly one transaction outstanding at any time.
REQ-015 IDLE: a grant is issued combinationally to one valid requester; the matching *_req_ready is high for that cycle only; the next state is REQ.
REQ-016 On a grant, addr, we, wdata, wmask and owner (IF/LS) are latched into holding registers; fetch grants latch we=0 and wmask=0.
REQ-017 REQ: mem_req_valid is 1 and mem_req_* are driven only from the holding registers; the state moves to RESP in the cycle mem_req_valid & mem_req_ready.
REQ-018 RESP: mem_req_valid is 0; when mem_resp_valid is 1, the owner's *_resp_valid equals 1 in the same cycle, *_resp_data equals mem_resp_data, and the next state is IDLE.
REQ-019 The non-owner's resp_valid is always 0; mem_resp_valid outside RESP is ignored.
REQ-020 Both req_ready outputs are 0 in REQ and RESP; the earliest new grant is the cycle after the response.
REQ-021 Latency with zero-wait memory: grant at cycle N, mem handshake at N+1, response at N+2 at the earliest; throughput is one transaction per 3 cycles.
REQ-022 Default arbitration is fixed priority: LS beats IF when both are valid.
REQ-023 Requesters hold request fields stable until their ready is seen; the arbiter does not depend on this after the grant cycle.
REQ-024 No timeout: REQ and RESP wait indefinitely.

Reset
REQ-025 While rst_n=0 at a clock edge: state=IDLE, owner=IF, the holding registers are 0, and the round-robin pointer (if present) points to IF.
REQ-026 Outputs during and after reset: mem_req_valid=0, if/ls_resp_valid=0, and req_ready is driven only per REQ-015.
REQ-027 Reset in REQ or RESP abandons the transaction; a late mem_resp_valid after reset is not forwarded.

Configuration
REQ-028 Macro ARB_ROUND_ROBIN_EN, when defined, enables round-robin arbitration: on a simultaneous request, the grant goes to the requester not granted last; a 1-bit pointer updates on every grant.
REQ-029 Without ARB_ROUND_ROBIN_EN, REQ-022 fixed priority applies and no pointer register exists.

Verification
REQ-030 Single fetch: if_req_valid with addr 0x80000000, memory returns 0x00100073 after 2 wait cycles -> if_resp_valid pulses once with data 0x00100073; ls_resp_valid stays 0.
REQ-031 Store: ls_req_we=1, addr 0x80001000, wdata 0xDEADBEEF, wmask 0xFF -> mem_req_* match the request while mem_req_ready=0; ls_resp_valid pulses on mem_resp_valid.
REQ-032 Simultaneous IF and LS valid for 2 transactions, macro undefined -> LS is granted twice in a row; with macro defined -> LS then IF.
REQ-033 mem_req_ready held 0 for 5 cycles -> mem_req_valid and fields are stable for all 5 cycles; both req_ready stay 0.
REQ-034 rst_n driven 0 for one cycle while in RESP, then a stray mem_resp_valid -> state is IDLE and no resp_valid pulses.
REQ-035 Zero-wait memory with back-to-back fetches -> grants occur every 3 cycles and addresses are delivered in order.
